// File: rtl/dma_channel_registers_pkg.sv
// Shared types and field layout for the DMA channel register file.
package dma_pkg;

  typedef logic [1:0] channel_t;

  // Mode register bits [7:2] as written by the CPU, MSB first.
  typedef struct packed {
    logic [1:0] mode;
    logic       addrDec;
    logic       autoInit;
    logic [1:0] transferType;
  } mode_t;

  localparam int unsigned MODE_AUTOINIT_BIT = 4;
  localparam int unsigned MODE_ADDR_DEC_BIT = 5;

  localparam int unsigned STATUS_TC_LSB   = 0;
  localparam int unsigned STATUS_DREQ_LSB = 4;
  localparam int unsigned STATUS_FIELD_W  = 4;

endpackage

// File: rtl/dma_channel_registers_if.sv
// CPU-side register bus: decoded strobes, channel select and data.
interface dma_channel_registers_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  loadCommandReg;
  logic                  loadModeReg;
  logic                  loadBaseAddressReg;
  logic                  ldBaseWordCountReg;
  logic                  readCurrentAddressReg;
  logic                  readCurrentWordCountReg;
  logic                  readStatusReg;
  logic                  clearInternalFF;
  logic                  writeSingleMask;
  logic [1:0]            A2A1;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataOutValid;

  modport master (
    output loadCommandReg, loadModeReg, loadBaseAddressReg, ldBaseWordCountReg,
    output readCurrentAddressReg, readCurrentWordCountReg, readStatusReg,
    output clearInternalFF, writeSingleMask, A2A1, dataIn,
    input  dataOut, dataOutValid
  );

  modport slave (
    input  loadCommandReg, loadModeReg, loadBaseAddressReg, ldBaseWordCountReg,
    input  readCurrentAddressReg, readCurrentWordCountReg, readStatusReg,
    input  clearInternalFF, writeSingleMask, A2A1, dataIn,
    output dataOut, dataOutValid
  );
endinterface

// File: rtl/dma_channel_registers_counter.sv
// One channel's base/current address and word-count registers.
module dma_channel_counter
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  write_addr,
  input  logic                  write_wc,
  input  logic                  byte_sel,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  step,
  input  logic                  addr_dec,
  input  logic                  auto_init,
  output logic [REG_WIDTH-1:0]  cur_addr,
  output logic [REG_WIDTH-1:0]  cur_wc,
  output logic                  tc
);

  logic [REG_WIDTH-1:0] base_addr, base_wc;
  logic [REG_WIDTH-1:0] next_addr, next_wc, next_base_addr, next_base_wc;

  assign tc = step && (cur_wc == '0);

  // Step (or autoinit reload on terminal count) first; a CPU byte write then overrides its byte only.
  always_comb begin
    next_addr      = cur_addr;
    next_wc        = cur_wc;
    next_base_addr = base_addr;
    next_base_wc   = base_wc;
    if (step) begin
      if (tc && auto_init) begin
        next_addr = base_addr;
        next_wc   = base_wc;
      end else begin
        next_addr = addr_dec ? cur_addr - 1'b1 : cur_addr + 1'b1;
        next_wc   = cur_wc - 1'b1;
      end
    end
    if (write_addr) begin
      if (byte_sel) begin
        next_addr[REG_WIDTH-1:DATA_WIDTH]      = data;
        next_base_addr[REG_WIDTH-1:DATA_WIDTH] = data;
      end else begin
        next_addr[DATA_WIDTH-1:0]      = data;
        next_base_addr[DATA_WIDTH-1:0] = data;
      end
    end
    if (write_wc) begin
      if (byte_sel) begin
        next_wc[REG_WIDTH-1:DATA_WIDTH]      = data;
        next_base_wc[REG_WIDTH-1:DATA_WIDTH] = data;
      end else begin
        next_wc[DATA_WIDTH-1:0]      = data;
        next_base_wc[DATA_WIDTH-1:0] = data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      base_addr <= '0;
      base_wc   <= '0;
      cur_addr  <= '0;
      cur_wc    <= '0;
    end else begin
      base_addr <= next_base_addr;
      base_wc   <= next_base_wc;
      cur_addr  <= next_addr;
      cur_wc    <= next_wc;
    end
  end

endmodule

// File: rtl/dma_channel_registers.sv
// DMA controller channel register file. Optional single-mask register: define DMA_MASK_REG_EN.
module dma_channel_registers
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned REG_WIDTH    = 16,
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  dma_channel_registers_if.slave        bus,
  input  logic [NUM_CHANNELS-1:0]       DREQ,
  input  logic                          stepValid,
  input  channel_t                      stepChannel,
  output logic [7:0]                    commandReg,
  output mode_t [NUM_CHANNELS-1:0]      modeReg,
  output logic [REG_WIDTH-1:0]          currentAddress,
  output logic                          tcPulse,
  output logic [NUM_CHANNELS-1:0]       mask
);

  logic [8:0] strobe, strobe_q;
  logic act_cmd, act_mode, act_base_addr, act_base_wc;
  logic act_rd_addr, act_rd_wc, act_rd_status, act_clr, act_single_mask;
  logic ff, step_ok;
  logic [NUM_CHANNELS-1:0] tc_hit, tc_status;
  logic [REG_WIDTH-1:0] cur_addr [NUM_CHANNELS];
  logic [REG_WIDTH-1:0] cur_wc   [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] status;
  channel_t ch;

  assign ch     = bus.A2A1;
  assign strobe = {bus.loadCommandReg, bus.loadModeReg, bus.loadBaseAddressReg,
                   bus.ldBaseWordCountReg, bus.readCurrentAddressReg,
                   bus.readCurrentWordCountReg, bus.readStatusReg,
                   bus.clearInternalFF, bus.writeSingleMask};

  // Strobes are levels held for the whole IOW_N/IOR_N pulse; act only on the rising edge.
  always_ff @(posedge CLK) begin
    if (RESET) strobe_q <= '0;
    else       strobe_q <= strobe;
  end

  assign {act_cmd, act_mode, act_base_addr, act_base_wc, act_rd_addr,
          act_rd_wc, act_rd_status, act_clr, act_single_mask} = strobe & ~strobe_q;

  always_ff @(posedge CLK) begin
    if (RESET || act_clr)
      ff <= 1'b0;
    else if (act_base_addr || act_base_wc || act_rd_addr || act_rd_wc)
      ff <= ~ff;
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    dma_channel_counter #(
      .DATA_WIDTH(DATA_WIDTH),
      .REG_WIDTH (REG_WIDTH)
    ) u_counter (
      .CLK       (CLK),
      .RESET     (RESET),
      .write_addr(act_base_addr && (ch == channel_t'(i))),
      .write_wc  (act_base_wc && (ch == channel_t'(i))),
      .byte_sel  (ff),
      .data      (bus.dataIn),
      .step      (step_ok && (stepChannel == channel_t'(i))),
      .addr_dec  (modeReg[i].addrDec),
      .auto_init (modeReg[i].autoInit),
      .cur_addr  (cur_addr[i]),
      .cur_wc    (cur_wc[i]),
      .tc        (tc_hit[i])
    );
  end

`ifdef DMA_MASK_REG_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++)
        if (tc_hit[i] && !modeReg[i].autoInit) mask[i] <= 1'b1;
      if (act_single_mask) mask[bus.dataIn[1:0]] <= bus.dataIn[2];
    end
  end
  assign step_ok = stepValid && !mask[stepChannel];
`else
  logic unused_single_mask;
  assign unused_single_mask = act_single_mask;
  assign mask    = '0;
  assign step_ok = stepValid;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      commandReg <= '0;
      modeReg    <= '0;
    end else begin
      if (act_cmd)  commandReg <= bus.dataIn;
      if (act_mode) modeReg[bus.dataIn[1:0]] <= mode_t'(bus.dataIn[7:2]);
    end
  end

  always_comb begin
    status = '0;
    status[STATUS_DREQ_LSB +: STATUS_FIELD_W] = DREQ;
    status[STATUS_TC_LSB   +: STATUS_FIELD_W] = tc_status;
  end

  // A terminal count landing in the same cycle as a status read survives the clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tc_status    <= '0;
      tcPulse      <= 1'b0;
      bus.dataOut      <= '0;
      bus.dataOutValid <= 1'b0;
    end else begin
      tc_status        <= (act_rd_status ? '0 : tc_status) | tc_hit;
      tcPulse          <= |tc_hit;
      bus.dataOutValid <= act_rd_addr || act_rd_wc || act_rd_status;
      if (act_rd_addr)
        bus.dataOut <= ff ? cur_addr[ch][REG_WIDTH-1:DATA_WIDTH] : cur_addr[ch][DATA_WIDTH-1:0];
      else if (act_rd_wc)
        bus.dataOut <= ff ? cur_wc[ch][REG_WIDTH-1:DATA_WIDTH] : cur_wc[ch][DATA_WIDTH-1:0];
      else if (act_rd_status)
        bus.dataOut <= status;
    end
  end

  assign currentAddress = cur_addr[stepChannel];

  a_one_strobe: assert property (@(posedge CLK) disable iff (RESET) $onehot0(strobe));

endmodule
